// File: rtl/picomips_pkg.sv
// Shared picoMIPS datapath definitions: default register-file geometry and the
// register address type.
package picomips_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NREGS  = 8;
  localparam int DEF_ADDR_W = $clog2(DEF_NREGS);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  localparam int ZERO_ADDR = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set by decode when a load
// issues and cleared by load write-back; two combinational lookups for stall checks.
module rf_scoreboard
  import picomips_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              busy1,
  output logic              busy2
);

  logic [NREGS-1:0] busy;

  // A set beats a clear on the same register: a new load has been issued
  // behind the one that is completing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (!(ZERO_REG != 0 && i == ZERO_ADDR)) begin
          if (set_en && set_addr == ADDR_W'(i)) begin
            busy[i] <= 1'b1;
          end else if (clr_en && clr_addr == ADDR_W'(i)) begin
            busy[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (raddr1 == ADDR_W'(i)) busy1 = busy[i];
      if (raddr2 == ADDR_W'(i)) busy2 = busy[i];
    end
  end

endmodule

// File: rtl/regfile_bypass.sv
// Two-write/two-read picoMIPS register file with write-to-read bypass, optional
// registered reads and a pending-load scoreboard.
module regfile_bypass
  import picomips_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  NREGS    = DEF_NREGS,
  parameter int  ZERO_REG = 1,
  parameter int  READ_REG = 0,
  localparam int ADDR_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              set_busy,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy1,
  output logic              busy2
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] byp1, byp2;

  function automatic logic reg_writable(input int idx);
    return !(ZERO_REG != 0 && idx == ZERO_ADDR);
  endfunction

  // Port B (load write-back) wins an address collision with port A.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (reg_writable(i)) begin
          if (wb_en && wb_addr == ADDR_W'(i)) begin
            regs[i] <= wb_data;
          end else if (wa_en && wa_addr == ADDR_W'(i)) begin
            regs[i] <= wa_data;
          end
        end
      end
    end
  end

  // Unmatched (out-of-range) and hardwired-zero addresses fall through to 0.
  function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (addr == ADDR_W'(i) && reg_writable(i)) begin
        if (wb_en && wb_addr == addr) v = wb_data;
        else if (wa_en && wa_addr == addr) v = wa_data;
        else v = regs[i];
      end
    end
    return v;
  endfunction

  always_comb begin
    byp1 = read_value(raddr1);
    byp2 = read_value(raddr2);
  end

  if (READ_REG != 0) begin : g_read_reg
    logic [DATA_W-1:0] rdata1_q, rdata2_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rdata1_q <= '0;
        rdata2_q <= '0;
      end else begin
        rdata1_q <= byp1;
        rdata2_q <= byp2;
      end
    end

    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;
  end else begin : g_read_comb
    assign rdata1 = byp1;
    assign rdata2 = byp2;
  end

  rf_scoreboard #(
    .NREGS   (NREGS),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .reset_n (reset_n),
    .set_en  (set_busy),
    .set_addr(set_addr),
    .clr_en  (wb_en),
    .clr_addr(wb_addr),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .busy1   (busy1),
    .busy2   (busy2)
  );

endmodule
